csr_wbmaster: RTL and testbench

CSR-programmable Wishbone bus initiator, used as a debug and maintenance master on one of the free conbus5x6 master ports (m2–m4). Software uses the CSR bus to load an address, data, word count and control word. The block then runs single or incrementing-burst read/write transactions on Wishbone. It reports completion and a running read checksum back through CSRs and an optional level interrupt.

---
 rtl/csr_wbmaster_if.sv | 22 ++
 rtl/csr_wbmaster.sv | 170 +++++++++++++++++
 tb/tb_csr_wbmaster.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_wbmaster_if.sv
// Wishbone initiator bundle for csr_wbmaster; signal names follow the master's view.
interface csr_wbmaster_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic [2:0]  wb_cti_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/csr_wbmaster.sv
// CSR-programmed Wishbone initiator running single or incrementing-burst transfers.
// Define CSR_WBMASTER_TIMEOUT_EN to abort a beat that sees no ack within TIMEOUT_CYCLES.
module csr_wbmaster #(
    parameter logic [3:0]  csr_addr       = 4'h0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [13:0]           csr_a,
    input  logic                  csr_we,
    input  logic [31:0]           csr_di,
    output logic [31:0]           csr_do,
    output logic                  irq,
    csr_wbmaster_if.master        wb
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;

    state_t      state_q;
    logic [31:0] addr_q, wdata_q, rdata_q, cksum_q, csr_do_q;
    logic [15:0] count_q, beats_q;
    logic        we_q, irq_en_q, done_q, err_q, cyc_q;
    logic [3:0]  sel_q;
    logic [2:0]  cti_q;
    logic [31:0] csr_do_d;

    logic page_hit, wr_en, idle, start_req, ack_beat, last_beat;
    logic unused_csr_a;

    assign unused_csr_a = ^csr_a[9:3];
    assign page_hit     = (csr_a[13:10] == csr_addr);
    assign wr_en        = csr_we & page_hit;
    assign idle         = (state_q == IDLE);
    assign start_req    = wr_en & idle & (csr_a[2:0] == 3'd4) & csr_di[0];
    assign ack_beat     = (state_q == ACTIVE) & wb.wb_ack_i;
    assign last_beat    = (beats_q == 16'd1);

    always_comb begin
        csr_do_d = 32'd0;
        if (page_hit) begin
            case (csr_a[2:0])
                3'd0:    csr_do_d = addr_q;
                3'd1:    csr_do_d = wdata_q;
                3'd2:    csr_do_d = rdata_q;
                3'd3:    csr_do_d = {16'd0, count_q};
                3'd4:    csr_do_d = {24'd0, sel_q, 1'b0, irq_en_q, we_q, ~idle};
                3'd5:    csr_do_d = {30'd0, err_q, done_q};
                3'd6:    csr_do_d = cksum_q;
                default: csr_do_d = 32'd0;
            endcase
        end
    end

`ifdef CSR_WBMASTER_TIMEOUT_EN
    logic [31:0] to_cnt_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            cksum_q  <= 32'd0;
            csr_do_q <= 32'd0;
            count_q  <= 16'd0;
            beats_q  <= 16'd0;
            we_q     <= 1'b0;
            irq_en_q <= 1'b0;
            sel_q    <= 4'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cyc_q    <= 1'b0;
            cti_q    <= 3'd0;
`ifdef CSR_WBMASTER_TIMEOUT_EN
            to_cnt_q <= 32'd0;
`endif
        end else begin
            csr_do_q <= csr_do_d;

            // Configuration is frozen while a transfer is in flight
            if (wr_en && idle) begin
                case (csr_a[2:0])
                    3'd0: addr_q  <= {csr_di[31:2], 2'b00};
                    3'd1: wdata_q <= csr_di;
                    3'd3: count_q <= csr_di[15:0];
                    3'd4: begin
                        we_q     <= csr_di[1];
                        irq_en_q <= csr_di[2];
                        sel_q    <= csr_di[7:4];
                    end
                    3'd6: cksum_q <= csr_di;
                    default: ;
                endcase
            end

            if (wr_en && (csr_a[2:0] == 3'd5)) begin
                if (csr_di[0]) done_q <= 1'b0;
                if (csr_di[1]) err_q  <= 1'b0;
            end

            // Status sets below are placed after the W1C so a coincident set wins
            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        err_q <= 1'b0;
                        if (count_q == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            done_q  <= 1'b0;
                            state_q <= ACTIVE;
                            beats_q <= count_q;
                            cyc_q   <= 1'b1;
                            cti_q   <= (count_q == 16'd1) ? 3'b000 : 3'b010;
`ifdef CSR_WBMASTER_TIMEOUT_EN
                            to_cnt_q <= 32'd0;
`endif
                        end
                    end
                end
                ACTIVE: begin
                    if (ack_beat) begin
                        addr_q <= addr_q + 32'd4;
                        if (!we_q) begin
                            rdata_q <= wb.wb_dat_i;
                            cksum_q <= cksum_q + wb.wb_dat_i;
                        end
                        if (last_beat) begin
                            state_q <= FINISH;
                            cyc_q   <= 1'b0;
                            cti_q   <= 3'b000;
                        end else begin
                            beats_q <= beats_q - 16'd1;
                            cti_q   <= (beats_q == 16'd2) ? 3'b111 : 3'b010;
                        end
`ifdef CSR_WBMASTER_TIMEOUT_EN
                        to_cnt_q <= 32'd0;
                    end else if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= IDLE;
                        cyc_q   <= 1'b0;
                        cti_q   <= 3'b000;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
`endif
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign csr_do       = csr_do_q;
    assign irq          = irq_en_q & (done_q | err_q);
    assign wb.wb_adr_o  = addr_q;
    assign wb.wb_dat_o  = wdata_q;
    assign wb.wb_sel_o  = sel_q;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_cti_o  = cti_q;
    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = cyc_q;

endmodule

// File: tb/tb_csr_wbmaster.sv
// Directed self-checking bench for csr_wbmaster with a delay-programmable Wishbone slave.
module tb_csr_wbmaster;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [13:0] csr_a   = 14'd0;
    logic        csr_we  = 1'b0;
    logic [31:0] csr_di  = 32'd0;
    logic [31:0] csr_do;
    logic        irq;

    csr_wbmaster_if wbif ();

    csr_wbmaster #(
        .csr_addr       (4'h0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_di  (csr_di),
        .csr_do  (csr_do),
        .irq     (irq),
        .wb      (wbif)
    );

    always #5 sys_clk = ~sys_clk;

    localparam logic [2:0] R_ADDR = 3'd0, R_WDATA = 3'd1, R_RDATA = 3'd2, R_COUNT = 3'd3,
                           R_CTRL = 3'd4, R_STATUS = 3'd5, R_CKSUM = 3'd6;

    int checks = 0;
    int errors = 0;

    // Slave model state and per-beat log
    int          dly [16];
    logic [31:0] rdv [16];
    logic [31:0] log_adr [16];
    logic [31:0] log_dat [16];
    logic [2:0]  log_cti [16];
    logic [3:0]  log_sel [16];
    logic        log_we  [16];
    int          beat_idx = 0;
    int          wcnt     = 0;
    int          hold_err = 0;
    bit          no_ack   = 1'b0;

    initial begin
        wbif.wb_ack_i = 1'b0;
        wbif.wb_dat_i = 32'd0;
    end

    always @(negedge sys_clk) begin
        if (wbif.wb_cyc_o && wbif.wb_stb_o && !sys_rst) begin
            if (wcnt == 0) begin
                log_adr[beat_idx % 16] = wbif.wb_adr_o;
                log_dat[beat_idx % 16] = wbif.wb_dat_o;
                log_cti[beat_idx % 16] = wbif.wb_cti_o;
                log_sel[beat_idx % 16] = wbif.wb_sel_o;
                log_we[beat_idx % 16]  = wbif.wb_we_o;
            end else if (wbif.wb_adr_o != log_adr[beat_idx % 16] ||
                         wbif.wb_dat_o != log_dat[beat_idx % 16] ||
                         wbif.wb_cti_o != log_cti[beat_idx % 16] ||
                         wbif.wb_we_o  != log_we[beat_idx % 16]) begin
                hold_err++;
            end
            if (!no_ack && wcnt >= dly[beat_idx % 16]) begin
                wbif.wb_ack_i = 1'b1;
                wbif.wb_dat_i = rdv[beat_idx % 16];
                beat_idx++;
                wcnt = 0;
            end else begin
                wbif.wb_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            wbif.wb_ack_i = 1'b0;
            wcnt = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic csr_wr(input logic [2:0] idx, input logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = {11'd0, idx};
        csr_di = d;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_rd_page(input logic [3:0] page, input logic [2:0] idx, output logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = {page, 7'd0, idx};
        csr_we = 1'b0;
        @(negedge sys_clk);
        d = csr_do;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] v;
        csr_rd_page(4'h0, idx, v);
        check_eq(tag, v, exp);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (wbif.wb_cyc_o && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 200) check_eq({tag, "_timeout"}, 32'(n), 32'd0);
        @(negedge sys_clk);
    endtask

    task automatic clear_log();
        beat_idx = 0;
        hold_err = 0;
        for (int i = 0; i < 16; i++) begin
            dly[i] = 0;
            rdv[i] = 32'd0;
        end
    endtask

    logic [31:0] v;

    initial begin
        clear_log();
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;

        // Reset state
        check_eq("rst_cyc", {31'd0, wbif.wb_cyc_o}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_adr", wbif.wb_adr_o, 32'd0);
        rd_chk("rst_ctrl", R_CTRL, 32'd0);
        rd_chk("rst_status", R_STATUS, 32'd0);

        // Single write
        clear_log();
        csr_wr(R_ADDR, 32'h0000_1003);
        csr_wr(R_WDATA, 32'hDEAD_BEEF);
        csr_wr(R_COUNT, 32'd1);
        csr_wr(R_CTRL, 32'hF3);
        wait_done("sw");
        check_eq("sw_beats", 32'(beat_idx), 32'd1);
        check_eq("sw_adr", log_adr[0], 32'h0000_1000);
        check_eq("sw_dat", log_dat[0], 32'hDEAD_BEEF);
        check_eq("sw_cti", {29'd0, log_cti[0]}, 32'd0);
        check_eq("sw_sel", {28'd0, log_sel[0]}, 32'hF);
        check_eq("sw_we", {31'd0, log_we[0]}, 32'd1);
        rd_chk("sw_status", R_STATUS, 32'd1);
        rd_chk("sw_ctrl", R_CTRL, 32'hF2);
        rd_chk("sw_addr", R_ADDR, 32'h0000_1004);
        csr_rd_page(4'h1, R_ADDR, v);
        check_eq("sw_other_page", v, 32'd0);

        // Burst read with uneven ack latency
        clear_log();
        dly[0] = 0; dly[1] = 2; dly[2] = 0; dly[3] = 5;
        rdv[0] = 1; rdv[1] = 2; rdv[2] = 3; rdv[3] = 4;
        csr_wr(R_CKSUM, 32'd0);
        csr_wr(R_ADDR, 32'h100);
        csr_wr(R_COUNT, 32'd4);
        csr_wr(R_CTRL, 32'hF1);
        wait_done("br");
        check_eq("br_beats", 32'(beat_idx), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("br_adr%0d", i), log_adr[i], 32'h100 + 32'(4 * i));
            check_eq($sformatf("br_cti%0d", i), {29'd0, log_cti[i]}, (i == 3) ? 32'd7 : 32'd2);
        end
        check_eq("br_hold", 32'(hold_err), 32'd0);
        rd_chk("br_rdata", R_RDATA, 32'd4);
        rd_chk("br_cksum", R_CKSUM, 32'd10);
        rd_chk("br_addr", R_ADDR, 32'h110);
        rd_chk("br_status", R_STATUS, 32'd1);

        // Address wrap across 2^32
        clear_log();
        rdv[0] = 5; rdv[1] = 6;
        csr_wr(R_ADDR, 32'hFFFF_FFFC);
        csr_wr(R_COUNT, 32'd2);
        csr_wr(R_CTRL, 32'hF1);
        wait_done("wr");
        check_eq("wrap_beats", 32'(beat_idx), 32'd2);
        check_eq("wrap_adr0", log_adr[0], 32'hFFFF_FFFC);
        check_eq("wrap_adr1", log_adr[1], 32'h0000_0000);
        check_eq("wrap_cti1", {29'd0, log_cti[1]}, 32'd7);
        rd_chk("wrap_addr", R_ADDR, 32'h4);
        rd_chk("wrap_cksum", R_CKSUM, 32'd21);

        // Zero-length start completes without a bus cycle
        clear_log();
        csr_wr(R_STATUS, 32'd1);
        rd_chk("z_status_clr", R_STATUS, 32'd0);
        csr_wr(R_COUNT, 32'd0);
        csr_wr(R_CTRL, 32'hF1);
        check_eq("z_cyc", {31'd0, wbif.wb_cyc_o}, 32'd0);
        rd_chk("z_status", R_STATUS, 32'd1);
        check_eq("z_beats", 32'(beat_idx), 32'd0);

        // Writes during a burst are ignored
        clear_log();
        dly[0] = 3; dly[1] = 3; dly[2] = 3;
        csr_wr(R_WDATA, 32'h1122_3344);
        csr_wr(R_COUNT, 32'd3);
        csr_wr(R_CTRL, 32'hF3);
        csr_wr(R_WDATA, 32'h55);
        csr_wr(R_CTRL, 32'h01);
        csr_wr(R_COUNT, 32'd7);
        wait_done("bp");
        repeat (4) @(negedge sys_clk);
        check_eq("bp_beats", 32'(beat_idx), 32'd3);
        check_eq("bp_dat2", log_dat[2], 32'h1122_3344);
        check_eq("bp_we2", {31'd0, log_we[2]}, 32'd1);
        check_eq("bp_hold", 32'(hold_err), 32'd0);
        rd_chk("bp_wdata", R_WDATA, 32'h1122_3344);
        rd_chk("bp_count", R_COUNT, 32'd3);

        // Level interrupt and W1C
        clear_log();
        csr_wr(R_COUNT, 32'd1);
        csr_wr(R_CTRL, 32'hF7);
        wait_done("irq");
        check_eq("irq_set", {31'd0, irq}, 32'd1);
        csr_wr(R_STATUS, 32'd1);
        check_eq("irq_clr", {31'd0, irq}, 32'd0);

`ifdef CSR_WBMASTER_TIMEOUT_EN
        // Beat never acknowledged
        begin
            int n = 0;
            clear_log();
            no_ack = 1'b1;
            csr_wr(R_ADDR, 32'h200);
            csr_wr(R_COUNT, 32'd2);
            csr_wr(R_CTRL, 32'hF5);
            while (wbif.wb_cyc_o && n < 100) begin
                n++;
                @(negedge sys_clk);
            end
            no_ack = 1'b0;
            check_eq("to_cycles", 32'(n), 32'd16);
            rd_chk("to_status", R_STATUS, 32'd3);
            rd_chk("to_addr", R_ADDR, 32'h200);
            check_eq("to_irq", {31'd0, irq}, 32'd1);
            csr_wr(R_STATUS, 32'd3);
        end
`endif

        // Reset in the middle of a burst
        clear_log();
        for (int i = 0; i < 4; i++) dly[i] = 5;
        csr_wr(R_ADDR, 32'h300);
        csr_wr(R_COUNT, 32'd4);
        csr_wr(R_CTRL, 32'hF1);
        check_eq("mr_cyc_pre", {31'd0, wbif.wb_cyc_o}, 32'd1);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_eq("mr_cyc", {31'd0, wbif.wb_cyc_o}, 32'd0);
        sys_rst = 1'b0;
        repeat (6) @(negedge sys_clk);
        check_eq("mr_no_beats", 32'(beat_idx), 32'd0);
        check_eq("mr_cyc_late", {31'd0, wbif.wb_cyc_o}, 32'd0);
        rd_chk("mr_addr", R_ADDR, 32'd0);
        rd_chk("mr_wdata", R_WDATA, 32'd0);
        rd_chk("mr_rdata", R_RDATA, 32'd0);
        rd_chk("mr_count", R_COUNT, 32'd0);
        rd_chk("mr_ctrl", R_CTRL, 32'd0);
        rd_chk("mr_status", R_STATUS, 32'd0);
        rd_chk("mr_cksum", R_CKSUM, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
